// File: rtl/keynsham_dma_pkg.sv
// Shared definitions for the keynsham word-copy DMA: register map,
// CTRL/STATUS bit positions and the copy-engine state encoding.
package keynsham_dma_defs;

  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DST   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  // CTRL write bits
  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_CLR_DONE  = 2;
  localparam int CTRL_CLR_ERROR = 3;

  // STATUS read bits
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } dma_state_e;

endpackage

// File: rtl/keynsham_dma_regs.sv
// Control-port responder: register decode/storage, status flags and the
// start/abort qualification that the copy engine acts on.
module keynsham_dma_regs
  import keynsham_dma_defs::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bus_access,
  input  logic                   bus_cs,
  input  logic [1:0]             bus_sel,
  input  logic [31:0]            bus_wr_val,
  input  logic                   bus_wr_en,
  output logic [31:0]            bus_data,
  output logic                   bus_ack,
  output logic                   bus_error,
  input  logic                   adv,
  input  logic                   set_done,
  input  logic                   set_error,
  input  logic                   clr_busy,
  output logic [31:0]            src,
  output logic [31:0]            dst,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   abort_pend,
  output logic                   start_go
);

  logic [31:0]            src_reg, dst_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   busy_reg, done_reg, error_reg, abort_pend_reg;
  logic                   bus_ack_reg, bus_error_reg;
  logic [31:0]            bus_data_reg;
  logic [31:0]            rd_val;

  logic acc, wr, wr_ctrl, wr_data_ok, start_req;

  assign acc        = bus_access & bus_cs;
  assign wr         = acc & bus_wr_en;
  assign wr_ctrl    = wr && (bus_sel == REG_CTRL);
  // Address/count registers are frozen while a transfer owns them.
  assign wr_data_ok = wr && (bus_sel != REG_CTRL) && !busy_reg;
  // Abort in the same write suppresses the start.
  assign start_req  = wr_ctrl && bus_wr_val[CTRL_START] && !bus_wr_val[CTRL_ABORT] && !busy_reg;
  assign start_go   = start_req && (count_reg != '0);

  always_comb begin
    rd_val = '0;
    case (bus_sel)
      REG_SRC:   rd_val = src_reg;
      REG_DST:   rd_val = dst_reg;
      REG_COUNT: rd_val = 32'(count_reg);
      default: begin
        rd_val[STAT_BUSY]  = busy_reg;
        rd_val[STAT_DONE]  = done_reg;
        rd_val[STAT_ERROR] = error_reg;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_reg        <= '0;
      dst_reg        <= '0;
      count_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      abort_pend_reg <= 1'b0;
      bus_ack_reg    <= 1'b0;
      bus_error_reg  <= 1'b0;
      bus_data_reg   <= '0;
    end else begin
      bus_ack_reg   <= acc;
      bus_error_reg <= wr && (bus_sel != REG_CTRL) && busy_reg;
      bus_data_reg  <= (acc && !bus_wr_en) ? rd_val : '0;

      if (wr_data_ok && bus_sel == REG_SRC) src_reg <= {bus_wr_val[31:2], 2'b00};
      else if (adv)                          src_reg <= src_reg + 32'd4;

      if (wr_data_ok && bus_sel == REG_DST) dst_reg <= {bus_wr_val[31:2], 2'b00};
      else if (adv)                          dst_reg <= dst_reg + 32'd4;

      if (wr_data_ok && bus_sel == REG_COUNT) count_reg <= bus_wr_val[COUNT_WIDTH-1:0];
      else if (adv)                            count_reg <= count_reg - COUNT_WIDTH'(1);

      // start_req only fires while idle, so it never collides with engine strobes.
      if (start_req) begin
        error_reg <= 1'b0;
        done_reg  <= (count_reg == '0);
        busy_reg  <= (count_reg != '0);
      end else begin
        if (clr_busy) busy_reg <= 1'b0;
        if (set_done)                                   done_reg <= 1'b1;
        else if (wr_ctrl && bus_wr_val[CTRL_CLR_DONE])  done_reg <= 1'b0;
        if (set_error)                                  error_reg <= 1'b1;
        else if (wr_ctrl && bus_wr_val[CTRL_CLR_ERROR]) error_reg <= 1'b0;
      end

      if (clr_busy)                                            abort_pend_reg <= 1'b0;
      else if (wr_ctrl && bus_wr_val[CTRL_ABORT] && busy_reg)  abort_pend_reg <= 1'b1;
    end
  end

  assign src        = src_reg;
  assign dst        = dst_reg;
  assign count      = count_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign abort_pend = abort_pend_reg;
  assign bus_data   = bus_data_reg;
  assign bus_ack    = bus_ack_reg;
  assign bus_error  = bus_error_reg;

endmodule

// File: rtl/keynsham_dma.sv
// Single-channel word-copy DMA: control-port registers plus a read-then-write
// initiator engine using the CPU-style access/ack/error handshake.
module keynsham_dma
  import keynsham_dma_defs::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_access,
  input  logic        bus_cs,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_wr_val,
  input  logic        bus_wr_en,
  input  logic [3:0]  bus_bytesel,
  output logic [31:0] bus_data,
  output logic        bus_ack,
  output logic        bus_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [31:0] m_wr_val,
  output logic        m_wr_en,
  output logic [3:0]  m_bytesel,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error,
  output logic        irq
);

  dma_state_e state_reg, state_next;
  logic [31:0] hold_reg;

  logic [31:0]            src, dst;
  logic [COUNT_WIDTH-1:0] count;
  logic busy, done, abort_pend, start_go;
  logic adv, set_done, set_error, clr_busy, capture;
  logic last_word;

  keynsham_dma_regs #(.COUNT_WIDTH(COUNT_WIDTH)) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_access (bus_access),
    .bus_cs     (bus_cs),
    .bus_sel    (bus_addr[1:0]),
    .bus_wr_val (bus_wr_val),
    .bus_wr_en  (bus_wr_en),
    .bus_data   (bus_data),
    .bus_ack    (bus_ack),
    .bus_error  (bus_error),
    .adv        (adv),
    .set_done   (set_done),
    .set_error  (set_error),
    .clr_busy   (clr_busy),
    .src        (src),
    .dst        (dst),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .abort_pend (abort_pend),
    .start_go   (start_go)
  );

  // Registers are full-word and the SoC decodes the upper address bits.
  logic unused_ok;
  assign unused_ok = ^{bus_bytesel, bus_addr[29:2], src[1:0], dst[1:0], busy};

  assign last_word = (count == COUNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) hold_reg <= m_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    adv        = 1'b0;
    set_done   = 1'b0;
    set_error  = 1'b0;
    clr_busy   = 1'b0;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE:    if (start_go) state_next = RD_REQ;
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: if (m_ack) begin
        if (m_error) begin
          set_error  = 1'b1;
          clr_busy   = 1'b1;
          state_next = IDLE;
        end else if (abort_pend) begin
          clr_busy   = 1'b1;
          state_next = IDLE;
        end else begin
          capture    = 1'b1;
          state_next = WR_REQ;
        end
      end
      WR_REQ:  state_next = WR_WAIT;
      WR_WAIT: if (m_ack) begin
        if (m_error) begin
          set_error  = 1'b1;
          clr_busy   = 1'b1;
          state_next = IDLE;
        end else begin
          // A pending abort still lets the completed write advance the pointers.
          adv = 1'b1;
          if (abort_pend) begin
            clr_busy   = 1'b1;
            state_next = IDLE;
          end else if (last_word) begin
            set_done   = 1'b1;
            clr_busy   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RD_REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_access  = (state_reg == RD_REQ) || (state_reg == WR_REQ);
  assign m_wr_en   = (state_reg == WR_REQ) || (state_reg == WR_WAIT);
  assign m_addr    = ((state_reg == RD_REQ) || (state_reg == RD_WAIT)) ? src[31:2] :
                     m_wr_en ? dst[31:2] : '0;
  assign m_wr_val  = m_wr_en ? hold_reg : '0;
  assign m_bytesel = 4'b1111;
  assign irq       = done;

endmodule

// File: doc/keynsham_dma.md
Name: keynsham_dma

Overview:
- Single-channel memory-to-memory word-copy engine for the keynsham SoC.
- On the data bus it is a responder for its four control registers, decoded at 0x80002000–0x80002fff by the SoC.
- It is also an initiator on a second data-bus port that the SoC arbitrates alongside the CPU. It issues the same access/ack/error handshake the CPU issues, so every existing responder works unchanged.

Parameters:
- COUNT_WIDTH, 16: width of the word-count register; maximum transfer is 2^COUNT_WIDTH-1 words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- bus_access  in  1  control-port access strobe, one cycle
- bus_cs  in  1  control-port chip select
- bus_addr  in  30  control-port word address; [1:0] selects the register
- bus_wr_val  in  32  control-port write data
- bus_wr_en  in  1  control-port write enable
- bus_bytesel  in  4  control-port byte select (ignored; registers are full-word)
- bus_data  out  32  control-port read data
- bus_ack  out  1  control-port acknowledge
- bus_error  out  1  control-port error, valid with bus_ack
- m_access  out  1  initiator access strobe
- m_addr  out  30  initiator word address
- m_wr_val  out  32  initiator write data
- m_wr_en  out  1  initiator write enable
- m_bytesel  out  4  initiator byte select, always 4'b1111
- m_data  in  32  initiator read data, valid with m_ack
- m_ack  in  1  initiator acknowledge
- m_error  in  1  initiator error, valid with m_ack
- irq  out  1  level interrupt, equal to STATUS.done

Behaviour:
- Reset (rst_n=0 at posedge): all registers 0, state IDLE, and all outputs 0 except m_bytesel=4'b1111. Reset mid-transfer drops the transfer immediately; a later stray m_ack is ignored.
- Control-port registers, selected by bus_addr[1:0]:
  - 0 SRC: byte address; bits [1:0] read as 0.
  - 1 DST: byte address; bits [1:0] read as 0.
  - 2 COUNT: words remaining, COUNT_WIDTH bits, zero-extended on read.
  - 3 CTRL/STATUS. Write: bit0 start, bit1 abort, bit2 W1C done, bit3 W1C error. Read: bit0 busy, bit1 done, bit2 error.
- Control-port handshake: bus_ack pulses the cycle after a bus_access with bus_cs high. bus_data is registered and valid in the same cycle as bus_ack; it is 0 when not acking.
- bus_error=1 with the ack when SRC, DST or COUNT is written while busy; the write is discarded. Reads never error.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE: a start write with abort=0 and busy=0 clears done and error.
  - If COUNT=0: done is set and no bus access is made.
  - Otherwise busy is set and the FSM goes to RD_REQ on the next edge.
- Start while busy is ignored. Start and abort in the same write: abort wins and nothing starts.
- RD_REQ: m_access=1 for exactly one cycle, m_addr=SRC[31:2], m_wr_en=0. Next state RD_WAIT.
- RD_WAIT: holds until m_ack.
  - On ack with m_error=0: capture m_data into a holding register, go to WR_REQ.
  - On ack with m_error=1: set error, clear busy, go to IDLE. No write is issued.
- WR_REQ: m_access=1 for one cycle, m_addr=DST[31:2], m_wr_en=1, m_wr_val=holding register. Next state WR_WAIT.
- WR_WAIT: on m_ack with m_error=0:
  - SRC+=4, DST+=4 (32-bit wrap, no error), COUNT-=1.
  - If the new COUNT is 0: set done, clear busy, go to IDLE. Otherwise go to RD_REQ.
  - On ack with m_error=1: set error, clear busy, go to IDLE; SRC, DST and COUNT are not advanced.
- m_addr, m_wr_en and m_wr_val hold their values throughout each WAIT state. m_access is never reasserted before the ack.
- Abort while busy sets a pending flag. It takes effect at the next m_ack: that access completes, the counters advance if the ack was a successful write, then busy clears and done stays 0.
- Per-word minimum latency with 1-cycle responders is 4 cycles.
- irq follows done and is cleared by W1C or by a start.

Decomposition:
- Package keynsham_dma_defs:
  - register offsets REG_SRC=0, REG_DST=1, REG_COUNT=2, REG_CTRL=3;
  - CTRL/STATUS bit indices;
  - FSM state encoding.
- Sub-module keynsham_dma_regs: control-port decode, register storage, bus_ack/bus_error generation. It exposes start/abort pulses and takes counter-advance and status-set strobes from the FSM in keynsham_dma.

Test Plan:
1. SRC=0x0, DST=0x100, COUNT=3, start; RAM words 0..2 = 0xA,0xB,0xC -> six m_access pulses (R,W,R,W,R,W) at word addresses 0,0x40,1,0x41,2,0x42; RAM 0x100..0x108 = A,B,C; final STATUS=0x2, COUNT=0, SRC=0xC, irq=1.
2. COUNT=0, start -> no m_access; STATUS=0x2 on the next read.
3. SRC=0x40000000 (unmapped; default responder errors) -> one read access, no write; STATUS=0x4, busy=0, COUNT unchanged.
4. COUNT=100, start, abort after 5 words -> the outstanding access completes, busy clears, done=0, COUNT=95 ±1 consistent with the completed access; no further m_access.
5. Write COUNT while busy -> bus_ack with bus_error=1, COUNT unchanged; then write CTRL=0x4 -> done and irq clear.
6. Drop rst_n during WR_WAIT -> m_access=0, all registers read 0 afterwards, a late m_ack causes no state change.
